// File: rtl/reg_wr_decoder_if.sv
// reg_wr_decoder_if
//   Bundles the issue, writeback and scoreboard signals of reg_wr_decoder.
//   slave  : decoder side (issue/writeback inputs, enables/scoreboard outputs)
//   master : driver side (control FSM, writeback stage, testbench)
//   Signals:
//     iss_valid, iss_addr[SEL_W] -> issue request and destination register
//     iss_ready                  <- issue accepted when iss_valid & iss_ready
//     wb_valid, wb_addr[SEL_W]   -> writeback strobe and destination register
//     flush                      -> discard all pending writes
//     wr_en[NREG]                <- registered one-hot register-file write enable
//     busy[NREG], busy_cnt[CNT_W]<- pending-write scoreboard and its popcount
//     wb_err                     <- only when REG_WR_DEC_CHK_EN is defined
interface reg_wr_decoder_if #(
    parameter int SEL_W = 4,
    parameter int CNT_W = SEL_W + 1
);
    localparam int NREG = 2 ** SEL_W;

    logic             iss_valid;
    logic [SEL_W-1:0] iss_addr;
    logic             iss_ready;
    logic             wb_valid;
    logic [SEL_W-1:0] wb_addr;
    logic             flush;
    logic [NREG-1:0]  wr_en;
    logic [NREG-1:0]  busy;
    logic [CNT_W-1:0] busy_cnt;
`ifdef REG_WR_DEC_CHK_EN
    logic             wb_err;
`endif

    modport slave (
        input  iss_valid, iss_addr, wb_valid, wb_addr, flush,
`ifdef REG_WR_DEC_CHK_EN
        output wb_err,
`endif
        output iss_ready, wr_en, busy, busy_cnt
    );

    modport master (
        output iss_valid, iss_addr, wb_valid, wb_addr, flush,
`ifdef REG_WR_DEC_CHK_EN
        input  wb_err,
`endif
        input  iss_ready, wr_en, busy, busy_cnt
    );
endinterface

// File: rtl/reg_wr_decoder.sv
// reg_wr_decoder
//   Register-file write-select decoder with a pending-write scoreboard.
//   Decodes the writeback address into a registered one-hot write enable and
//   tracks which destinations have an issued-but-not-written-back result so
//   the control FSM can stall on a busy destination.
//   Optional feature macro: REG_WR_DEC_CHK_EN adds wb_err, a registered
//   one-cycle pulse flagging a writeback to a register that was not busy.
//   Ports:
//     i_clk   : system clock, all state on rising edge
//     i_rst_n : synchronous reset, active low
//     bus     : reg_wr_decoder_if.slave (issue, writeback, flush, wr_en,
//               busy, busy_cnt, optional wb_err)
module reg_wr_decoder #(
    parameter int SEL_W = 4,
    parameter int CNT_W = SEL_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    reg_wr_decoder_if.slave       bus
);
    localparam int NREG = 2 ** SEL_W;
    localparam logic [NREG-1:0] ONE_HOT_0 = NREG'(1);

    logic [NREG-1:0]  r_wr_en;
    logic [NREG-1:0]  r_busy;
    logic [CNT_W-1:0] r_busy_cnt;

    logic             w_iss_ready;
    logic             w_iss_acc;
    logic             w_wb_clr;
    logic [NREG-1:0]  w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NREG-1:0]  w_wr_en_nxt;

    // No bypass from a same-cycle writeback: a busy destination stalls even
    // if its result is being written back right now.
    assign w_iss_ready = ~bus.flush & ~r_busy[bus.iss_addr];
    assign w_iss_acc   = bus.iss_valid & w_iss_ready;
    assign w_wb_clr    = bus.wb_valid & r_busy[bus.wb_addr];

    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.flush) begin
            w_busy_nxt = '0;
        end else begin
            // Clear before set: an accepted issue to a non-busy register
            // coinciding with an untracked writeback to it stays pending.
            if (bus.wb_valid) w_busy_nxt[bus.wb_addr] = 1'b0;
            if (w_iss_acc)    w_busy_nxt[bus.iss_addr] = 1'b1;
        end
    end

    // An accepted issue and a clearing writeback can never target the same
    // register (issue requires the bit clear), so deltas net exactly.
    always_comb begin
        w_cnt_nxt = r_busy_cnt;
        if (bus.flush) begin
            w_cnt_nxt = '0;
        end else if (w_iss_acc && !w_wb_clr) begin
            w_cnt_nxt = r_busy_cnt + CNT_W'(1);
        end else if (!w_iss_acc && w_wb_clr) begin
            w_cnt_nxt = r_busy_cnt - CNT_W'(1);
        end
    end

    assign w_wr_en_nxt = bus.wb_valid ? (ONE_HOT_0 << bus.wb_addr) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_en    <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_wr_en    <= w_wr_en_nxt;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

`ifdef REG_WR_DEC_CHK_EN
    logic r_wb_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wb_err <= 1'b0;
        end else begin
            r_wb_err <= bus.wb_valid & ~r_busy[bus.wb_addr] & ~bus.flush;
        end
    end

    assign bus.wb_err = r_wb_err;
`endif

    assign bus.iss_ready = w_iss_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.busy      = r_busy;
    assign bus.busy_cnt  = r_busy_cnt;
endmodule

// File: tb/tb_reg_wr_decoder.sv
module tb_reg_wr_decoder;
    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: set of pending destinations plus last-cycle expectations.
    logic [15:0] m_busy = '0;
    logic [15:0] m_wr   = '0;
    logic        m_err  = 1'b0;

    reg_wr_decoder_if #(.SEL_W(4)) bus ();

    reg_wr_decoder #(.SEL_W(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, check iss_ready, advance the
    // reference from the pre-edge state, then check registered outputs.
    task automatic step(input logic iv, input logic [3:0] ia,
                        input logic wv, input logic [3:0] wa, input logic fl);
        logic [15:0] nb;
        logic        rdy;
        @(negedge clk);
        bus.iss_valid = iv;
        bus.iss_addr  = ia;
        bus.wb_valid  = wv;
        bus.wb_addr   = wa;
        bus.flush     = fl;
        #1;
        rdy = !fl && !m_busy[ia];
        if (rst_n) chk("iss_ready", {31'b0, bus.iss_ready}, {31'b0, rdy});
        nb = m_busy;
        if (!rst_n || fl) begin
            nb = '0;
        end else begin
            if (wv) nb[wa] = 1'b0;
            if (iv && rdy) nb[ia] = 1'b1;
        end
        m_err = rst_n && wv && !m_busy[wa] && !fl;
        m_wr  = (rst_n && wv) ? (16'(1) << wa) : 16'h0000;
        @(posedge clk);
        #1;
        m_busy = nb;
        chk("wr_en", {16'b0, bus.wr_en}, {16'b0, m_wr});
        chk("busy", {16'b0, bus.busy}, {16'b0, m_busy});
        chk("busy_cnt", {27'b0, bus.busy_cnt}, $countones(m_busy));
`ifdef REG_WR_DEC_CHK_EN
        chk("wb_err", {31'b0, bus.wb_err}, {31'b0, m_err});
`endif
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.flush     = 1'b0;

        // Reset held while traffic is driven.
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)), 1'b0);
        chk("rst_busy", {16'b0, bus.busy}, 32'h0);
        chk("rst_cnt", {27'b0, bus.busy_cnt}, 32'h0);
        rst_n = 1'b1;
        idle();

        // Decode sweep.
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 4'd0, 1'b1, 4'(a), 1'b0);
            chk("sweep", {16'b0, bus.wr_en}, 32'(1) << a);
        end
        idle();
        chk("sweep_off", {16'b0, bus.wr_en}, 32'h0);

        // Scoreboard basics.
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        chk("sb_busy", {16'b0, bus.busy}, 32'h0088);
        chk("sb_cnt", {27'b0, bus.busy_cnt}, 32'd2);
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        chk("sb_refuse", {16'b0, bus.busy}, 32'h0088);
        step(1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
        chk("sb_wr", {16'b0, bus.wr_en}, 32'h0008);
        chk("sb_busy2", {16'b0, bus.busy}, 32'h0080);
        chk("sb_cnt2", {27'b0, bus.busy_cnt}, 32'd1);

        // Same-cycle issue/writeback.
        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 1'b1, 4'd5, 1'b0);
        chk("same_busy", {16'b0, bus.busy}, 32'h0080);
        chk("same_cnt", {27'b0, bus.busy_cnt}, 32'd1);
        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd2, 1'b1, 4'd5, 1'b0);
        chk("diff_busy", {16'b0, bus.busy}, 32'h0084);
        chk("diff_cnt", {27'b0, bus.busy_cnt}, 32'd2);

        // Flush with concurrent issue and writeback.
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int a = 0; a < 16; a++)
            if (a < 4 || a > 11) step(1'b1, 4'(a), 1'b0, 4'd0, 1'b0);
        chk("fl_pre", {16'b0, bus.busy}, 32'hF00F);
        chk("fl_pre_cnt", {27'b0, bus.busy_cnt}, 32'd8);
        step(1'b1, 4'd9, 1'b1, 4'd1, 1'b1);
        chk("fl_busy", {16'b0, bus.busy}, 32'h0);
        chk("fl_cnt", {27'b0, bus.busy_cnt}, 32'd0);
        chk("fl_wr", {16'b0, bus.wr_en}, 32'h0002);

`ifdef REG_WR_DEC_CHK_EN
        step(1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
        chk("err_set", {31'b0, bus.wb_err}, 32'd1);
        chk("err_wr", {16'b0, bus.wr_en}, 32'h0010);
        idle();
        chk("err_pulse", {31'b0, bus.wb_err}, 32'd0);
        step(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
        chk("err_busy", {31'b0, bus.wb_err}, 32'd0);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
